axi4_lite_ps_to_pl_reg_slave: RTL and testbench



---
 rtl/axi4_lite_ps_to_pl_reg_slave_pkg.sv | 25 ++
 rtl/axi4_lite_write_channel_fsm.sv | 104 ++++++++++
 rtl/axi4_lite_ps_to_pl_reg_slave.sv | 164 ++++++++++++++++
 tb/tb_axi4_lite_ps_to_pl_reg_slave.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_ps_to_pl_reg_slave_pkg.sv
// Shared types for the PS-to-PL AXI4-Lite control-register slave.
// Covers the FSM state enums, the AXI response codes and the register index type.
package axi4_lite_ps_to_pl_reg_slave_pkg;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_HAVE_ADDR = 2'd1,
    WR_HAVE_DATA = 2'd2,
    WR_RESP      = 2'd3
  } wrState_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rdState_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int REG_NUM_DEFAULT = 16;
  localparam int REG_IDX_W       = $clog2(REG_NUM_DEFAULT);

  typedef logic [REG_IDX_W-1:0] regIndex_t;

endpackage

// File: rtl/axi4_lite_write_channel_fsm.sv
// AW/W/B handshake for the control-register slave. Address and data may arrive in either
// order; commit_o pulses combinationally on the edge a write to an implemented register lands.
module axi4_lite_write_channel_fsm
  import axi4_lite_ps_to_pl_reg_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       awAddr_i,
  input  logic                        awValid_i,
  output logic                        awReady_o,
  input  logic [DATA_WIDTH-1:0]       wData_i,
  input  logic [DATA_WIDTH/8-1:0]     wStrb_i,
  input  logic                        wValid_i,
  output logic                        wReady_o,
  output logic [1:0]                  bResp_o,
  output logic                        bValid_o,
  input  logic                        bReady_i,
  output logic                        commit_o,
  output logic [$clog2(REG_NUM)-1:0]  index_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic [DATA_WIDTH/8-1:0]     strb_o
);

  localparam int WORD_W = ADDR_WIDTH - 2;

  wrState_e                  stateQ, stateD;
  logic [WORD_W-1:0]         addrQ, addrD;
  logic [DATA_WIDTH-1:0]     dataQ, dataD;
  logic [DATA_WIDTH/8-1:0]   strbQ, strbD;
  logic [1:0]                bRespQ, bRespD;
  logic                      awHs, wHs, commit, inRange;
  logic [WORD_W-1:0]         wordIdx;
  logic                      unusedAddrBits;

  assign unusedAddrBits = ^awAddr_i[1:0];

  assign awReady_o = (stateQ == WR_IDLE) || (stateQ == WR_HAVE_DATA);
  assign wReady_o  = (stateQ == WR_IDLE) || (stateQ == WR_HAVE_ADDR);
  assign bValid_o  = (stateQ == WR_RESP);
  assign bResp_o   = bRespQ;

  assign awHs = awValid_i && awReady_o;
  assign wHs  = wValid_i && wReady_o;

  // Whichever half was latched earlier comes from its holding register, the other from the bus.
  assign wordIdx = (stateQ == WR_HAVE_ADDR) ? addrQ : awAddr_i[ADDR_WIDTH-1:2];
  assign data_o  = (stateQ == WR_HAVE_DATA) ? dataQ : wData_i;
  assign strb_o  = (stateQ == WR_HAVE_DATA) ? strbQ : wStrb_i;
  assign inRange = int'(wordIdx) < REG_NUM;
  assign index_o = wordIdx[$clog2(REG_NUM)-1:0];
  assign commit_o = commit && inRange;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= WR_IDLE;
      addrQ  <= '0;
      dataQ  <= '0;
      strbQ  <= '0;
      bRespQ <= AXI_RESP_OKAY;
    end else begin
      stateQ <= stateD;
      addrQ  <= addrD;
      dataQ  <= dataD;
      strbQ  <= strbD;
      bRespQ <= bRespD;
    end
  end

  always_comb begin
    stateD = stateQ;
    addrD  = addrQ;
    dataD  = dataQ;
    strbD  = strbQ;
    bRespD = bRespQ;
    commit = 1'b0;
    case (stateQ)
      WR_IDLE: begin
        if (awHs && wHs) begin
          commit = 1'b1;
        end else if (awHs) begin
          addrD  = awAddr_i[ADDR_WIDTH-1:2];
          stateD = WR_HAVE_ADDR;
        end else if (wHs) begin
          dataD  = wData_i;
          strbD  = wStrb_i;
          stateD = WR_HAVE_DATA;
        end
      end
      WR_HAVE_ADDR: commit = wHs;
      WR_HAVE_DATA: commit = awHs;
      WR_RESP: if (bReady_i) stateD = WR_IDLE;
      default: stateD = WR_IDLE;
    endcase
    if (commit) begin
      bRespD = inRange ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      stateD = WR_RESP;
    end
  end

endmodule

// File: rtl/axi4_lite_ps_to_pl_reg_slave.sv
// PS-to-PL control-register bank behind an AXI4-Lite slave, with core-side write-back.
// Define RSD_AXI_LITE_WSTRB_EN to honour WSTRB byte lanes; otherwise writes are full-word.
module axi4_lite_ps_to_pl_reg_slave
  import axi4_lite_ps_to_pl_reg_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_WIDTH-1:0]         AWADDR,
  input  logic [2:0]                    AWPROT,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [DATA_WIDTH-1:0]         WDATA,
  input  logic [DATA_WIDTH/8-1:0]       WSTRB,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [ADDR_WIDTH-1:0]         ARADDR,
  input  logic [2:0]                    ARPROT,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [DATA_WIDTH-1:0]         RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [REG_NUM*DATA_WIDTH-1:0] regOut,
  output logic                          axiWritePulse,
  output logic [$clog2(REG_NUM)-1:0]    axiWriteIndex,
  input  logic                          plWe,
  input  logic [$clog2(REG_NUM)-1:0]    plIndex,
  input  logic [DATA_WIDTH-1:0]         plData
);

  localparam int IDX_W = $clog2(REG_NUM);

  logic [DATA_WIDTH-1:0]   regQ [REG_NUM];
  logic [DATA_WIDTH-1:0]   regD [REG_NUM];
  logic                    wrCommit;
  logic [IDX_W-1:0]        wrIndex;
  logic [DATA_WIDTH-1:0]   wrData;
  logic [DATA_WIDTH/8-1:0] wrStrb;
  logic                    pulseQ;
  logic [IDX_W-1:0]        indexQ;
  rdState_e                rdStateQ, rdStateD;
  logic [DATA_WIDTH-1:0]   rDataQ, rDataD;
  logic [1:0]              rRespQ, rRespD;
  logic                    arHs, rdInRange;
  logic [ADDR_WIDTH-3:0]   rdWord;
  logic                    unusedInputs;

`ifdef RSD_AXI_LITE_WSTRB_EN
  assign unusedInputs = ^{AWPROT, ARPROT, ARADDR[1:0]};
`else
  assign unusedInputs = ^{AWPROT, ARPROT, ARADDR[1:0], WSTRB, wrStrb};
`endif

  axi4_lite_write_channel_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .REG_NUM   (REG_NUM)
  ) uWriteFsm (
    .clk      (clk),
    .rst      (rst),
    .awAddr_i (AWADDR),
    .awValid_i(AWVALID),
    .awReady_o(AWREADY),
    .wData_i  (WDATA),
    .wStrb_i  (WSTRB),
    .wValid_i (WVALID),
    .wReady_o (WREADY),
    .bResp_o  (BRESP),
    .bValid_o (BVALID),
    .bReady_i (BREADY),
    .commit_o (wrCommit),
    .index_o  (wrIndex),
    .data_o   (wrData),
    .strb_o   (wrStrb)
  );

  // AXI commit is applied after the core write so it wins on an index collision.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      regD[i] = regQ[i];
      if (plWe && (plIndex == IDX_W'(i))) regD[i] = plData;
      if (wrCommit && (wrIndex == IDX_W'(i))) begin
`ifdef RSD_AXI_LITE_WSTRB_EN
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
          if (wrStrb[b]) regD[i][b*8 +: 8] = wrData[b*8 +: 8];
        end
`else
        regD[i] = wrData;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regQ[i] <= '0;
      pulseQ <= 1'b0;
      indexQ <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) regQ[i] <= regD[i];
      pulseQ <= wrCommit;
      indexQ <= wrIndex;
    end
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : gRegOut
    assign regOut[g*DATA_WIDTH +: DATA_WIDTH] = regQ[g];
  end

  assign axiWritePulse = pulseQ;
  assign axiWriteIndex = indexQ;

  assign ARREADY   = (rdStateQ == RD_IDLE);
  assign RVALID    = (rdStateQ == RD_DATA);
  assign RDATA     = rDataQ;
  assign RRESP     = rRespQ;
  assign arHs      = ARVALID && ARREADY;
  assign rdWord    = ARADDR[ADDR_WIDTH-1:2];
  assign rdInRange = int'(rdWord) < REG_NUM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdStateQ <= RD_IDLE;
      rDataQ   <= '0;
      rRespQ   <= AXI_RESP_OKAY;
    end else begin
      rdStateQ <= rdStateD;
      rDataQ   <= rDataD;
      rRespQ   <= rRespD;
    end
  end

  // Read data is sampled from regQ, so a same-edge AXI write returns the pre-write value.
  always_comb begin
    rdStateD = rdStateQ;
    rDataD   = rDataQ;
    rRespD   = rRespQ;
    case (rdStateQ)
      RD_IDLE: begin
        if (arHs) begin
          rdStateD = RD_DATA;
          if (rdInRange) begin
            rDataD = regQ[rdWord[IDX_W-1:0]];
            rRespD = AXI_RESP_OKAY;
          end else begin
            rDataD = '0;
            rRespD = AXI_RESP_SLVERR;
          end
        end
      end
      RD_DATA: if (RREADY) rdStateD = RD_IDLE;
      default: rdStateD = RD_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_ps_to_pl_reg_slave.sv
// Directed self-checking bench for axi4_lite_ps_to_pl_reg_slave.
// Expectations follow RSD_AXI_LITE_WSTRB_EN when the byte-strobe case is exercised.
module tb_axi4_lite_ps_to_pl_reg_slave;
  import axi4_lite_ps_to_pl_reg_slave_pkg::*;

  logic          clk;
  logic          rst;
  logic [6:0]    AWADDR;
  logic [2:0]    AWPROT;
  logic          AWVALID;
  logic          AWREADY;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic          WVALID;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY;
  logic [6:0]    ARADDR;
  logic [2:0]    ARPROT;
  logic          ARVALID;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY;
  logic [511:0]  regOut;
  logic          axiWritePulse;
  logic [3:0]    axiWriteIndex;
  logic          plWe;
  regIndex_t     plIndex;
  logic [31:0]   plData;

  logic [31:0]   expReg [16];
  int            checkCount;
  int            passCount;

  axi4_lite_ps_to_pl_reg_slave dut (
    .clk          (clk),
    .rst          (rst),
    .AWADDR       (AWADDR),
    .AWPROT       (AWPROT),
    .AWVALID      (AWVALID),
    .AWREADY      (AWREADY),
    .WDATA        (WDATA),
    .WSTRB        (WSTRB),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .BRESP        (BRESP),
    .BVALID       (BVALID),
    .BREADY       (BREADY),
    .ARADDR       (ARADDR),
    .ARPROT       (ARPROT),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .regOut       (regOut),
    .axiWritePulse(axiWritePulse),
    .axiWriteIndex(axiWriteIndex),
    .plWe         (plWe),
    .plIndex      (plIndex),
    .plData       (plData)
  );

  // Free-running 100 MHz clock; all stimulus and sampling happen on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a wedged run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic checkAllRegs(input string tag);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("%s_r%0d", tag, i), {32'd0, regOut[i*32 +: 32]}, {32'd0, expReg[i]});
  endtask

  // Drive AW and W together, check the response cycle, then retire it with BREADY.
  task automatic applyStimulus(input string tag, input logic [6:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] expResp,
                               input logic expPulse, input logic [3:0] expIdx);
    @(negedge clk);
    AWADDR = addr; AWVALID = 1'b1; WDATA = data; WSTRB = strb; WVALID = 1'b1; BREADY = 1'b0;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    checkOutput({tag, "_bvalid"}, 64'(BVALID), 64'd1);
    checkOutput({tag, "_bresp"}, 64'(BRESP), 64'(expResp));
    checkOutput({tag, "_pulse"}, 64'(axiWritePulse), 64'(expPulse));
    if (expPulse) checkOutput({tag, "_index"}, 64'(axiWriteIndex), 64'(expIdx));
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    checkOutput({tag, "_bdone"}, 64'(BVALID), 64'd0);
    checkOutput({tag, "_pulseEnd"}, 64'(axiWritePulse), 64'd0);
  endtask

  task automatic axiRead(input string tag, input logic [6:0] addr, input logic [31:0] expData,
                         input logic [1:0] expResp);
    @(negedge clk);
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b0;
    @(negedge clk);
    ARVALID = 1'b0;
    checkOutput({tag, "_rvalid"}, 64'(RVALID), 64'd1);
    checkOutput({tag, "_arready"}, 64'(ARREADY), 64'd0);
    checkOutput({tag, "_rdata"}, 64'(RDATA), 64'(expData));
    checkOutput({tag, "_rresp"}, 64'(RRESP), 64'(expResp));
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    checkOutput({tag, "_rdone"}, 64'(RVALID), 64'd0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    for (int i = 0; i < 16; i++) expReg[i] = 32'd0;
    rst = 1'b1;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = 4'hF; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    plWe = 1'b0; plIndex = '0; plData = '0;

    // Reset held
    repeat (3) @(negedge clk);
    checkOutput("rst_awready", 64'(AWREADY), 64'd1);
    checkOutput("rst_wready", 64'(WREADY), 64'd1);
    checkOutput("rst_arready", 64'(ARREADY), 64'd1);
    checkOutput("rst_bvalid", 64'(BVALID), 64'd0);
    checkOutput("rst_rvalid", 64'(RVALID), 64'd0);
    checkOutput("rst_rdata", 64'(RDATA), 64'd0);
    checkOutput("rst_pulse", 64'(axiWritePulse), 64'd0);
    checkOutput("rst_regOutZero", 64'(regOut == '0), 64'd1);

    // Reset released, still idle
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_awready", 64'(AWREADY), 64'd1);
    checkOutput("idle_wready", 64'(WREADY), 64'd1);
    checkOutput("idle_arready", 64'(ARREADY), 64'd1);
    checkOutput("idle_bvalid", 64'(BVALID), 64'd0);
    checkOutput("idle_rvalid", 64'(RVALID), 64'd0);

    // Simultaneous AW/W then read back
    applyStimulus("wrSim", 7'h08, 32'hDEADBEEF, 4'hF, AXI_RESP_OKAY, 1'b1, 4'd2);
    expReg[2] = 32'hDEADBEEF;
    axiRead("rdSim", 7'h08, 32'hDEADBEEF, AXI_RESP_OKAY);

    // W three cycles ahead of AW, BREADY withheld for five cycles
    @(negedge clk);
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
    @(negedge clk);
    WVALID = 1'b0;
    checkOutput("wFirst_awready", 64'(AWREADY), 64'd1);
    checkOutput("wFirst_wready", 64'(WREADY), 64'd0);
    repeat (2) @(negedge clk);
    AWADDR = 7'h04; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    checkOutput("wFirst_pulseIdx", 64'({axiWritePulse, axiWriteIndex}), 64'({1'b1, 4'd1}));
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("wFirst_bhold%0d", c), 64'({BVALID, BRESP}), 64'({1'b1, AXI_RESP_OKAY}));
      @(negedge clk);
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    expReg[1] = 32'h12345678;
    checkOutput("wFirst_bdone", 64'(BVALID), 64'd0);
    checkOutput("wFirst_reg1", 64'(regOut[32 +: 32]), 64'h12345678);

    // Out-of-range write and read
    applyStimulus("wrOor", 7'h40, 32'hFFFFFFFF, 4'hF, AXI_RESP_SLVERR, 1'b0, 4'd0);
    checkAllRegs("oorNoChange");
    axiRead("rdOor", 7'h40, 32'd0, AXI_RESP_SLVERR);

    // Same-index conflict: AXI wins over plWe
    @(negedge clk);
    AWADDR = 7'h0C; AWVALID = 1'b1; WDATA = 32'h00005555; WSTRB = 4'hF; WVALID = 1'b1;
    plWe = 1'b1; plIndex = 4'd3; plData = 32'hAAAA0000;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; plWe = 1'b0; BREADY = 1'b1;
    checkOutput("conflict_reg3", 64'(regOut[3*32 +: 32]), 64'h00005555);
    @(negedge clk);
    BREADY = 1'b0;
    expReg[3] = 32'h00005555;

    // Different indices on the same edge: both land
    @(negedge clk);
    AWADDR = 7'h10; AWVALID = 1'b1; WDATA = 32'h00000044; WVALID = 1'b1;
    plWe = 1'b1; plIndex = 4'd5; plData = 32'h0BADF00D;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; plWe = 1'b0; BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    expReg[4] = 32'h00000044;
    expReg[5] = 32'h0BADF00D;
    checkOutput("dual_reg4", 64'(regOut[4*32 +: 32]), 64'h00000044);
    checkOutput("dual_reg5", 64'(regOut[5*32 +: 32]), 64'h0BADF00D);

    // plWe alone, visible the cycle after its edge
    @(negedge clk);
    plWe = 1'b1; plIndex = 4'd6; plData = 32'hCAFE0001;
    @(negedge clk);
    plWe = 1'b0;
    expReg[6] = 32'hCAFE0001;
    checkOutput("plWe_reg6", 64'(regOut[6*32 +: 32]), 64'hCAFE0001);
    axiRead("rdPl", 7'h18, 32'hCAFE0001, AXI_RESP_OKAY);

    // AR on the same edge as a commit to the same register returns the old value
    @(negedge clk);
    AWADDR = 7'h08; AWVALID = 1'b1; WDATA = 32'h11112222; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 7'h08; ARVALID = 1'b1; BREADY = 1'b0; RREADY = 1'b0;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    expReg[2] = 32'h11112222;
    checkOutput("rw_rdataOld", 64'(RDATA), 64'hDEADBEEF);
    checkOutput("rw_bothValid", 64'({RVALID, BVALID}), 64'b11);
    checkOutput("rw_reg2New", 64'(regOut[2*32 +: 32]), 64'h11112222);
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0; RREADY = 1'b0;

    // Byte strobes
    applyStimulus("strbFill", 7'h00, 32'hFFFFFFFF, 4'hF, AXI_RESP_OKAY, 1'b1, 4'd0);
    applyStimulus("strbPart", 7'h00, 32'h00000000, 4'b0011, AXI_RESP_OKAY, 1'b1, 4'd0);
`ifdef RSD_AXI_LITE_WSTRB_EN
    expReg[0] = 32'hFFFF0000;
`else
    expReg[0] = 32'h00000000;
`endif
    checkOutput("strb_reg0", 64'(regOut[31:0]), 64'(expReg[0]));
    checkAllRegs("final");

    // Asynchronous reset with a write half-accepted
    @(negedge clk);
    WDATA = 32'h77777777; WVALID = 1'b1;
    @(negedge clk);
    WVALID = 1'b0;
    checkOutput("midRst_preWready", 64'(WREADY), 64'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRst_regOutZero", 64'(regOut == '0), 64'd1);
    checkOutput("midRst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'b111);
    checkOutput("midRst_bvalid", 64'(BVALID), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("postRst_bvalid", 64'(BVALID), 64'd0);
    checkOutput("postRst_wready", 64'(WREADY), 64'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
